// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter in front of a single-port synchronous block RAM: byte-to-word
// address conversion, data-port range/alignment check and a registered req/ack return path.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32'sd13,
    parameter int DATA_W   = 32'sd32,
    parameter int ARB_MODE = 32'sd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAP   = 3'd2,
        WR_ISSUE = 3'd3,
        ACK      = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              gnt_d_r;
    logic              gnt_d_nxt_s;
    logic              last_d_r;
    logic              last_d_nxt_s;
    logic              pick_d_s;
    logic              d_bad_s;
    logic              mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_din_nxt_s;
    logic [DATA_W-1:0] i_rdata_nxt_s;
    logic              i_ack_nxt_s;
    logic [DATA_W-1:0] d_rdata_nxt_s;
    logic              d_ack_nxt_s;
    logic              d_err_nxt_s;
    logic              unused_i_addr_s;

    function automatic logic addr_bad_f(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
    endfunction

    // The fetch port is deliberately unchecked, so its byte-offset and upper bits go nowhere.
    assign unused_i_addr_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};
    assign d_bad_s         = addr_bad_f(d_addr);

    // Winner selection; last_d_r resets to 0 so round-robin favours the data port first
    always_comb begin
        pick_d_s = 1'b0;
        if (d_req && i_req) begin
            if (ARB_MODE == 32'sd0) begin
                pick_d_s = 1'b1;
            end else begin
                pick_d_s = ~last_d_r;
            end
        end else begin
            pick_d_s = d_req;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s    = state_r;
        gnt_d_nxt_s    = gnt_d_r;
        last_d_nxt_s   = last_d_r;
        mem_we_nxt_s   = 1'b0;
        mem_addr_nxt_s = mem_addr;
        mem_din_nxt_s  = mem_din;
        i_rdata_nxt_s  = i_rdata;
        i_ack_nxt_s    = 1'b0;
        d_rdata_nxt_s  = d_rdata;
        d_ack_nxt_s    = 1'b0;
        d_err_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req || i_req) begin
                    gnt_d_nxt_s  = pick_d_s;
                    last_d_nxt_s = pick_d_s;
                    if (pick_d_s) begin
                        if (d_bad_s) begin
                            // Rejected access never reaches the RAM; complete it straight away.
                            d_ack_nxt_s   = 1'b1;
                            d_err_nxt_s   = 1'b1;
                            d_rdata_nxt_s = {DATA_W{1'b0}};
                            state_nxt_s   = ACK;
                        end else begin
                            mem_addr_nxt_s = d_addr[ADDR_W+1:2];
                            if (d_we) begin
                                mem_we_nxt_s  = 1'b1;
                                mem_din_nxt_s = d_wdata;
                                state_nxt_s   = WR_ISSUE;
                            end else begin
                                state_nxt_s = RD_ISSUE;
                            end
                        end
                    end else begin
                        mem_addr_nxt_s = i_addr[ADDR_W+1:2];
                        state_nxt_s    = RD_ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_ISSUE: begin
                state_nxt_s = RD_CAP;
            end
            RD_CAP: begin
                if (gnt_d_r) begin
                    d_rdata_nxt_s = mem_dout;
                    d_ack_nxt_s   = 1'b1;
                end else begin
                    i_rdata_nxt_s = mem_dout;
                    i_ack_nxt_s   = 1'b1;
                end
                state_nxt_s = ACK;
            end
            WR_ISSUE: begin
                d_ack_nxt_s = 1'b1;
                state_nxt_s = ACK;
            end
            ACK: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and arbitration history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            gnt_d_r  <= 1'b0;
            last_d_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            gnt_d_r  <= gnt_d_nxt_s;
            last_d_r <= last_d_nxt_s;
        end
    end

    // Registered outputs; reset clears everything, including an in-flight mem_we
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= {ADDR_W{1'b0}};
            mem_din  <= {DATA_W{1'b0}};
            i_rdata  <= {DATA_W{1'b0}};
            i_ack    <= 1'b0;
            d_rdata  <= {DATA_W{1'b0}};
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            mem_we   <= mem_we_nxt_s;
            mem_addr <= mem_addr_nxt_s;
            mem_din  <= mem_din_nxt_s;
            i_rdata  <= i_rdata_nxt_s;
            i_ack    <= i_ack_nxt_s;
            d_rdata  <= d_rdata_nxt_s;
            d_ack    <= d_ack_nxt_s;
            d_err    <= d_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one fixed-priority and one round-robin instance, each with its
// own behavioural RAM; table vectors, directed timing sequences and randomized traffic.
module tb_mem_bus_arbiter;
    localparam int AW = 13;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req   [2];
    logic [31:0] i_addr  [2];
    logic [31:0] i_rdata [2];
    logic        i_ack   [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];
    logic        d_ack   [2];
    logic        d_err   [2];

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] shadow [2][256];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          we_cnt;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int k);
        if (k == 5) return 32'hDEAD_BEEF;
        return 32'(k) * 32'h9E37_79B9 + 32'h1357_2468;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_din;
        logic [DW-1:0] mem_dout;
        logic [DW-1:0] ram [2**AW];
        bit            wr  [2**AW];

        mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(g)) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_rdata(d_rdata[g]), .d_ack(d_ack[g]), .d_err(d_err[g]),
            .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
        );

        // Synchronous RAM: write on we, otherwise registered read; unwritten words read init_val
        always @(posedge clk) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_din;
                wr[mem_addr]  <= 1'b1;
            end else begin
                mem_dout <= wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_xact(input int g, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int we_cnt, output logic [AW-1:0] we_addr);
        d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wdata; d_req[g] = 1'b1;
        lat = 0; we_cnt = 0; we_addr = '0;
        while (lat < 20) begin
            step();
            lat++;
            if (g == 0 && g_dut[0].mem_we === 1'b1) begin
                we_cnt++;
                we_addr = g_dut[0].mem_addr;
            end
            if (d_ack[g] === 1'b1) break;
            chk("d_err_without_ack", d_err[g], 1'b0);
        end
        chk("d_ack_seen", d_ack[g], 1'b1);
        err = d_err[g]; rdata = d_rdata[g];
        d_req[g] = 1'b0;
        step();
        chk("d_ack_one_cycle", d_ack[g], 1'b0);
    endtask

    task automatic i_xact(input int g, input logic [31:0] addr, output int lat, output logic [31:0] rdata);
        i_addr[g] = addr; i_req[g] = 1'b1;
        lat = 0;
        while (lat < 20) begin
            step();
            lat++;
            if (i_ack[g] === 1'b1) break;
        end
        chk("i_ack_seen", i_ack[g], 1'b1);
        rdata = i_rdata[g];
        i_req[g] = 1'b0;
        step();
        chk("i_ack_one_cycle", i_ack[g], 1'b0);
    endtask

    task automatic rand_d(input int g);
        int lat, wc, kind, w;
        logic err, we;
        logic [31:0] rd, a, wd;
        logic [AW-1:0] wa;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, 255);
            a    = {17'h0, 13'(1024 + w), 2'b00};
            wd   = $urandom;
            if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 1) a[31:15] = 17'($urandom_range(1, 131071));
            we = (kind < 2) ? 1'($urandom_range(0, 1)) : (kind < 6);
            d_xact(g, we, a, wd, lat, err, rd, wc, wa);
            chk("rand_d_err", err, (kind < 2));
            if (kind < 2) chk("rand_d_err_rdata", rd, 32'h0);
            else if (!we) chk("rand_d_load", rd, shadow[g][w]);
            else shadow[g][w] = wd;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_i(input int g);
        int lat, w;
        logic [31:0] rd;
        for (int n = 0; n < 60; n++) begin
            w = $urandom_range(0, 255);
            i_xact(g, {17'($urandom), 13'(2048 + w), 2'($urandom)}, lat, rd);
            chk("rand_i_fetch", rd, init_val(2048 + w));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, wc, t_d, t_i, na;
        int ack_t [6];
        logic ack_d [6];
        logic err;
        logic [31:0] rd;
        logic [AW-1:0] wa;

        tbl[0] = '{1'b1, 32'h0000_7FFC, 32'h1234_5678, 1'b0, 32'h0, 2, 1};
        tbl[1] = '{1'b0, 32'h0000_7FFC, 32'h0,         1'b0, 32'h1234_5678, 3, 0};
        tbl[2] = '{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0, 1, 0};
        tbl[3] = '{1'b0, 32'h0000_8000, 32'h0,         1'b1, 32'h0, 1, 0};
        tbl[4] = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 1'b0, 32'h0, 2, 1};
        tbl[5] = '{1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'hA5A5_A5A5, 3, 0};
        tbl[6] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0};
        tbl[7] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, init_val(0), 3, 0};
        tbl[8] = '{1'b1, 32'hFFFF_0000, 32'h0BAD_0BAD, 1'b1, 32'h0, 1, 0};
        tbl[9] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, init_val(1), 3, 0};

        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            i_req[g] = 1'b0; i_addr[g] = 32'h0; d_req[g] = 1'b0; d_we[g] = 1'b0;
            d_addr[g] = 32'h0; d_wdata[g] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_i_ack", i_ack[g], 1'b0);
            chk("rst_i_rdata", i_rdata[g], 32'h0);
            chk("rst_d_ack", d_ack[g], 1'b0);
            chk("rst_d_err", d_err[g], 1'b0);
            chk("rst_d_rdata", d_rdata[g], 32'h0);
        end
        chk("rst_mem_we0", g_dut[0].mem_we, 1'b0);
        chk("rst_mem_addr0", 32'(g_dut[0].mem_addr), 32'h0);
        chk("rst_mem_din0", g_dut[0].mem_din, 32'h0);
        chk("rst_mem_we1", g_dut[1].mem_we, 1'b0);
        rst = 1'b0;
        step();

        i_xact(0, 32'h0000_0014, lat, rd);
        chk("fetch_latency", lat, 3);
        chk("fetch_data", rd, 32'hDEAD_BEEF);

        for (int k = 0; k < 10; k++) begin
            d_xact(0, tbl[k].we, tbl[k].addr, tbl[k].wdata, lat, err, rd, wc, wa);
            chk($sformatf("vec%0d_latency", k), lat, tbl[k].lat);
            chk($sformatf("vec%0d_err", k), err, tbl[k].err);
            chk($sformatf("vec%0d_mem_we_cycles", k), wc, tbl[k].we_cnt);
            if (tbl[k].we_cnt == 1) chk($sformatf("vec%0d_mem_addr", k), 32'(wa), 32'(tbl[k].addr[14:2]));
            if (!tbl[k].we || tbl[k].err) chk($sformatf("vec%0d_rdata", k), rd, tbl[k].rdata);
        end

        // Simultaneous load and fetch on the fixed-priority instance
        d_we[0] = 1'b0; d_addr[0] = 32'h0000_0100; i_addr[0] = 32'h0000_0014;
        d_req[0] = 1'b1; i_req[0] = 1'b1;
        t_d = 0; t_i = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (d_ack[0] === 1'b1) begin t_d = c; d_req[0] = 1'b0; chk("conf0_d_rdata", d_rdata[0], 32'hA5A5_A5A5); end
            if (i_ack[0] === 1'b1) begin t_i = c; i_req[0] = 1'b0; chk("conf0_i_rdata", i_rdata[0], 32'hDEAD_BEEF); end
            if (t_d != 0 && t_i != 0) break;
        end
        d_req[0] = 1'b0; i_req[0] = 1'b0;
        step();
        chk("conf0_d_ack_time", t_d, 3);
        chk("conf0_i_ack_time", t_i, 7);

        // Fetch held continuously: acks four cycles apart, none doubled
        i_addr[0] = 32'h0000_0014; i_req[0] = 1'b1;
        na = 0;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (i_ack[0] === 1'b1) begin
                if (na < 6) ack_t[na] = c;
                na++;
                if (na == 3) i_req[0] = 1'b0;
            end
        end
        i_req[0] = 1'b0;
        chk("b2b_ack_count", na, 3);
        for (int k = 0; k < 3 && k < na; k++) chk($sformatf("b2b_ack%0d_time", k), ack_t[k], 3 + 4 * k);

        // Reset while the fetch sits in RD_CAP
        i_addr[0] = 32'h0000_0014; i_req[0] = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("rstmid_i_ack", i_ack[0], 1'b0);
        chk("rstmid_i_rdata", i_rdata[0], 32'h0);
        chk("rstmid_d_rdata", d_rdata[0], 32'h0);
        chk("rstmid_mem_addr", 32'(g_dut[0].mem_addr), 32'h0);
        chk("rstmid_mem_din", g_dut[0].mem_din, 32'h0);
        i_req[0] = 1'b0;
        step();
        chk("rstmid_no_ack", i_ack[0], 1'b0);
        rst = 1'b0;
        step();
        chk("rstmid_no_ack_after", i_ack[0], 1'b0);
        i_xact(0, 32'h0000_0014, lat, rd);
        chk("rstmid_reissue_latency", lat, 3);
        chk("rstmid_reissue_data", rd, 32'hDEAD_BEEF);

        // Round-robin instance, both ports held: grants must alternate D, I, D, ...
        d_we[1] = 1'b0; d_addr[1] = 32'h0000_0104; i_addr[1] = 32'h0000_0018;
        d_req[1] = 1'b1; i_req[1] = 1'b1;
        na = 0;
        for (int c = 1; c <= 30 && na < 6; c++) begin
            step();
            if (d_ack[1] === 1'b1 && i_ack[1] === 1'b1) chk("rr_single_ack", 32'h2, 32'h1);
            if (d_ack[1] === 1'b1 || i_ack[1] === 1'b1) begin
                ack_t[na] = c;
                ack_d[na] = d_ack[1];
                na++;
            end
        end
        d_req[1] = 1'b0; i_req[1] = 1'b0;
        step();
        chk("rr_ack_count", na, 6);
        for (int k = 0; k < na; k++) begin
            chk($sformatf("rr_grant%0d_port_is_data", k), ack_d[k], (k % 2 == 0));
            chk($sformatf("rr_grant%0d_time", k), ack_t[k], 3 + 4 * k);
        end
        chk("rr_d_rdata", d_rdata[1], init_val(65));
        chk("rr_i_rdata", i_rdata[1], init_val(6));

        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 256; k++) shadow[g][k] = init_val(1024 + k);
        fork
            rand_i(0);
            rand_d(0);
            rand_i(1);
            rand_d(1);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
